// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with tick prescaler, up/down count, wrap pulse and lap-capture FIFO (STOPWATCH_LAP_EN).
// Latency: start edge is a counting edge; lap entry visible on lap_valid one cycle after lap.
// Backpressure: lap FIFO drains on lap_valid & lap_ready; a lap into a full FIFO is dropped and sets lap_ovf.

module sw_lap_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         push_rdy_o,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    input  logic         pop_rdy_i
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         empty, full, push, pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = ~empty & pop_rdy_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_rdy_o = ~full | pop_rdy_i;
    assign push       = push_vld_i & push_rdy_o;

    assign pop_vld_o = ~empty;
    assign pop_dat_o = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop  ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end
    end
endmodule

module stopwatch_lap_timer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int PRESCALE   = 1,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  dir,
    input  logic                  lap,
    input  logic                  lap_ready,
    output logic                  lap_valid,
    output logic [DATA_WIDTH-1:0] lap_data,
    output logic                  lap_ovf,
    output logic                  running,
    output logic                  wrap,
    output logic [DATA_WIDTH-1:0] count
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]         PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_V    = DATA_WIDTH'(MAX);

    if (MAX < 0 || longint'(MAX) >= (longint'(1) << DATA_WIDTH)) begin : g_bad_max
        $error("stopwatch_lap_timer: MAX out of range for DATA_WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("stopwatch_lap_timer: PRESCALE must be >= 1");
    end
    if (LAP_DEPTH < 2 || (LAP_DEPTH & (LAP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stopwatch_lap_timer: LAP_DEPTH must be a power of 2 >= 2");
    end

    typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

    state_t                state_q;
    logic [PW-1:0]         pre_q, pre_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic                  run_eff, tick;

    assign run_eff = (start | (state_q == ST_RUNNING)) & ~stop;
    assign tick    = run_eff & (pre_q == PRE_LAST);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        if (run_eff) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        if (tick) begin
            if (!dir) begin
                if (count_q == MAX_V) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
        // Clear beats a coincident tick but leaves the run state alone.
        if (clear) begin
            count_d = '0;
            pre_d   = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_STOPPED;
            pre_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= run_eff ? ST_RUNNING : ST_STOPPED;
            pre_q   <= pre_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running = (state_q == ST_RUNNING);
    assign wrap    = wrap_q;
    assign count   = count_q;

`ifdef STOPWATCH_LAP_EN
    logic push_rdy;
    logic lap_ovf_q;

    // Lap captures the register value before this edge, so a same-cycle clear is not seen.
    sw_lap_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_vld_i (lap),
        .push_dat_i (count_q),
        .push_rdy_o (push_rdy),
        .pop_vld_o  (lap_valid),
        .pop_dat_o  (lap_data),
        .pop_rdy_i  (lap_ready)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lap_ovf_q <= 1'b0;
        end else if (clear) begin
            lap_ovf_q <= 1'b0;
        end else if (lap && !push_rdy) begin
            lap_ovf_q <= 1'b1;
        end
    end

    assign lap_ovf = lap_ovf_q;
`else
    logic unused_lap;

    assign unused_lap = lap ^ lap_ready;
    assign lap_valid  = 1'b0;
    assign lap_data   = '0;
    assign lap_ovf    = 1'b0;
`endif
endmodule
